// File: rtl/fir_ctrl_pkg.sv
// Shared constants and state encoding for the FIR tap scheduler.
package fir_ctrl_pkg;

    localparam int unsigned NUM_BANK   = 4;
    localparam int unsigned BANK_DEPTH = 10;
    localparam int unsigned NUM_COEFF  = NUM_BANK * BANK_DEPTH;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned SEL_W      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_SWEEP,
        S_DRAIN,
        S_ADD
    } state_t;

endpackage

// File: rtl/fir_tap_scheduler_if.sv
// Host coefficient stream, sample strobe and SRAM/MAC control bundle.
interface fir_tap_scheduler_if
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned P_NUM_BANK = NUM_BANK,
    parameter int unsigned P_DATA_W   = DATA_W,
    parameter int unsigned P_ADDR_W   = ADDR_W
);

    logic                  iEnSample_300k;
    logic                  iCoeffUpdate;
    logic                  iCoeffValid;
    logic [P_DATA_W-1:0]   iCoeffData;
    logic                  oCoeffReady;
    logic [P_NUM_BANK-1:0] oCsnRam;
    logic [P_NUM_BANK-1:0] oWrnRam;
    logic [P_ADDR_W-1:0]   oAddrRam;
    logic [P_DATA_W-1:0]   oWrDtRam;
    logic [SEL_W-1:0]      oSel;
    logic                  oEnAcc;
    logic                  oEnAdd;
    logic                  oSumValid;
    logic                  oLoadDone;
    logic                  oBusy;
    logic                  oOverrun;

    modport master (
        output iEnSample_300k, iCoeffUpdate, iCoeffValid, iCoeffData,
        input  oCoeffReady, oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oSel,
               oEnAcc, oEnAdd, oSumValid, oLoadDone, oBusy, oOverrun
    );

    modport slave (
        input  iEnSample_300k, iCoeffUpdate, iCoeffValid, iCoeffData,
        output oCoeffReady, oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oSel,
               oEnAcc, oEnAdd, oSumValid, oLoadDone, oBusy, oOverrun
    );

endinterface

// File: rtl/fir_coeff_addr_gen.sv
// Nested bank/address counter for coefficient loading; terminal count
// replaces a divide-by-depth on the linear coefficient index.
module fir_coeff_addr_gen
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned P_NUM_BANK   = NUM_BANK,
    parameter int unsigned P_BANK_DEPTH = BANK_DEPTH,
    parameter int unsigned P_ADDR_W     = ADDR_W,
    parameter int unsigned P_BANK_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                advance,
    output logic [P_BANK_W-1:0] bank,
    output logic [P_ADDR_W-1:0] addr,
    output logic                last
);

    localparam logic [P_BANK_W-1:0] BANK_LAST = P_BANK_W'(P_NUM_BANK - 1);
    localparam logic [P_ADDR_W-1:0] ADDR_LAST = P_ADDR_W'(P_BANK_DEPTH - 1);

    logic addr_wrap;

    assign addr_wrap = (addr == ADDR_LAST);
    assign last      = addr_wrap && (bank == BANK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
            addr <= '0;
        end else if (clear) begin
            bank <= '0;
            addr <= '0;
        end else if (advance) begin
            if (addr_wrap) begin
                addr <= '0;
                bank <= last ? '0 : bank + P_BANK_W'(1);
            end else begin
                addr <= addr + P_ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fir_tap_scheduler.sv
// Coefficient-load and tap-sweep sequencer for the 4-bank transposed FIR.
module fir_tap_scheduler
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned P_NUM_BANK   = NUM_BANK,
    parameter int unsigned P_BANK_DEPTH = BANK_DEPTH,
    parameter int unsigned P_DATA_W     = DATA_W,
    parameter int unsigned P_ADDR_W     = ADDR_W
) (
    input logic                iClk_12M,
    input logic                iRsn,
    fir_tap_scheduler_if.slave bus
);

    localparam int unsigned BW = (P_NUM_BANK > 1) ? $clog2(P_NUM_BANK) : 1;
    localparam logic [P_ADDR_W-1:0] TAP_LAST = P_ADDR_W'(P_BANK_DEPTH - 1);

    state_t                state, state_next;
    logic [P_ADDR_W-1:0]   tap, tap_next;
    logic                  pending, overrun;
    logic                  xfer, enter_load, in_sweep;
    logic [BW-1:0]         coeff_bank;
    logic [P_ADDR_W-1:0]   coeff_addr;
    logic                  coeff_last;
    logic [P_NUM_BANK-1:0] bank_sel;

    logic                  ready, en_acc, en_add, sum_valid, load_done, busy;
    logic [P_NUM_BANK-1:0] csn, wrn;
    logic [P_ADDR_W-1:0]   addr_ram;
    logic [P_DATA_W-1:0]   wr_data;
    logic [SEL_W-1:0]      sel;

    assign xfer       = bus.iCoeffValid & ready;
    assign in_sweep   = state inside {S_SWEEP, S_DRAIN, S_ADD};
    assign enter_load = (state_next == S_LOAD) && (state != S_LOAD);

    fir_coeff_addr_gen #(
        .P_NUM_BANK  (P_NUM_BANK),
        .P_BANK_DEPTH(P_BANK_DEPTH),
        .P_ADDR_W    (P_ADDR_W),
        .P_BANK_W    (BW)
    ) u_addr_gen (
        .clk    (iClk_12M),
        .rst_n  (iRsn),
        .clear  (enter_load),
        .advance(xfer),
        .bank   (coeff_bank),
        .addr   (coeff_addr),
        .last   (coeff_last)
    );

    always_comb begin
        bank_sel             = '1;
        bank_sel[coeff_bank] = 1'b0;
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) state <= S_IDLE;
        else       state <= state_next;
    end

    // Update wins over a coincident strobe in ARMED; a latched update
    // diverts the end of a sweep straight into LOAD.
    always_comb begin
        state_next = state;
        tap_next   = '0;
        unique case (state)
            S_IDLE:  if (bus.iCoeffUpdate) state_next = S_LOAD;
            S_LOAD:  if (xfer && coeff_last) state_next = S_ARMED;
            S_ARMED: begin
                if (bus.iCoeffUpdate)        state_next = S_LOAD;
                else if (bus.iEnSample_300k) state_next = S_SWEEP;
            end
            S_SWEEP: begin
                if (tap == TAP_LAST) state_next = S_DRAIN;
                else                 tap_next   = tap + P_ADDR_W'(1);
            end
            S_DRAIN: state_next = S_ADD;
            S_ADD:   state_next = (pending || bus.iCoeffUpdate) ? S_LOAD : S_ARMED;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            tap       <= '0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            en_acc    <= 1'b0;
            en_add    <= 1'b0;
            sum_valid <= 1'b0;
            sel       <= '0;
            csn       <= '1;
            wrn       <= '1;
            addr_ram  <= '0;
            wr_data   <= '0;
        end else begin
            tap       <= tap_next;
            ready     <= (state_next == S_LOAD);
            busy      <= state_next inside {S_LOAD, S_SWEEP, S_DRAIN, S_ADD};
            load_done <= xfer & coeff_last;
            // Read data lags the address by one cycle, so select/acc trail SWEEP.
            en_acc    <= (state == S_SWEEP);
            sel       <= (state == S_SWEEP) ? SEL_W'(tap) : '0;
            en_add    <= (state_next == S_ADD);
            sum_valid <= (state == S_ADD);

            if (enter_load) begin
                pending <= 1'b0;
                overrun <= 1'b0;
            end else if (in_sweep) begin
                if (bus.iCoeffUpdate)   pending <= 1'b1;
                if (bus.iEnSample_300k) overrun <= 1'b1;
            end

            if (xfer) begin
                csn      <= bank_sel;
                wrn      <= bank_sel;
                addr_ram <= coeff_addr;
                wr_data  <= bus.iCoeffData;
            end else if (state_next == S_SWEEP) begin
                csn      <= '0;
                wrn      <= '1;
                addr_ram <= tap_next;
            end else begin
                csn      <= '1;
                wrn      <= '1;
                addr_ram <= '0;
            end
        end
    end

    assign bus.oCoeffReady = ready;
    assign bus.oCsnRam     = csn;
    assign bus.oWrnRam     = wrn;
    assign bus.oAddrRam    = addr_ram;
    assign bus.oWrDtRam    = wr_data;
    assign bus.oSel        = sel;
    assign bus.oEnAcc      = en_acc;
    assign bus.oEnAdd      = en_add;
    assign bus.oSumValid   = sum_valid;
    assign bus.oLoadDone   = load_done;
    assign bus.oBusy       = busy;
    assign bus.oOverrun    = overrun;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Scoreboard bench: expected SRAM writes and sweep cycles are queued as
// stimulus is driven and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_fir_tap_scheduler;
    import fir_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #42 clk = ~clk;

    fir_tap_scheduler_if bus_if ();

    fir_tap_scheduler dut (
        .iClk_12M(clk),
        .iRsn    (rst_n),
        .bus     (bus_if)
    );

    typedef struct packed {
        logic [1:0]  bank;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        last;
    } wr_t;

    typedef struct packed {
        logic [3:0] csn;
        logic [3:0] addr;
        logic       acc;
        logic [3:0] sel;
        logic       add;
        logic       sv;
    } sw_t;

    wr_t sb_w[$];
    sw_t sb_s[$];
    int  total = 0;
    int  bad   = 0;
    int  write_count;
    int  done_count;
    int  hits[40];

    task automatic monitor();
        wr_t        ew;
        sw_t        es, as;
        logic [3:0] ecsn;
        int         slot;
        forever begin
            @(negedge clk);
            if (bus_if.oLoadDone) done_count++;
            if ((~bus_if.oCsnRam & ~bus_if.oWrnRam) != 4'h0) begin
                write_count++;
                slot = -1;
                for (int b = 0; b < 4; b++)
                    if (!bus_if.oCsnRam[b]) slot = b * 10 + int'(bus_if.oAddrRam);
                if (slot >= 0 && slot < 40) hits[slot]++;
                total++;
                if (sb_w.size() == 0) begin
                    bad++;
                    $display("FAIL write_unexpected got csn=%h wrn=%h addr=%0d data=%h want no write",
                             bus_if.oCsnRam, bus_if.oWrnRam, bus_if.oAddrRam, bus_if.oWrDtRam);
                end else begin
                    ew   = sb_w.pop_front();
                    ecsn = ~(4'b0001 << ew.bank);
                    if (bus_if.oCsnRam !== ecsn || bus_if.oWrnRam !== ecsn ||
                        bus_if.oAddrRam !== ew.addr || bus_if.oWrDtRam !== ew.data ||
                        bus_if.oLoadDone !== ew.last) begin
                        bad++;
                        $display("FAIL write k=%0d got csn=%h wrn=%h addr=%0d data=%h done=%b want csn=%h wrn=%h addr=%0d data=%h done=%b",
                                 ew.bank * 10 + ew.addr, bus_if.oCsnRam, bus_if.oWrnRam, bus_if.oAddrRam,
                                 bus_if.oWrDtRam, bus_if.oLoadDone, ecsn, ecsn, ew.addr, ew.data, ew.last);
                    end
                end
            end else if (bus_if.oCsnRam != 4'hF || bus_if.oEnAcc || bus_if.oEnAdd || bus_if.oSumValid) begin
                total++;
                if (sb_s.size() == 0) begin
                    bad++;
                    $display("FAIL sweep_unexpected got csn=%h acc=%b add=%b sv=%b want idle",
                             bus_if.oCsnRam, bus_if.oEnAcc, bus_if.oEnAdd, bus_if.oSumValid);
                end else begin
                    es      = sb_s.pop_front();
                    as.csn  = bus_if.oCsnRam;
                    as.addr = (es.csn == 4'h0) ? bus_if.oAddrRam : 4'h0;
                    as.acc  = bus_if.oEnAcc;
                    as.sel  = es.acc ? bus_if.oSel : 4'h0;
                    as.add  = bus_if.oEnAdd;
                    as.sv   = bus_if.oSumValid;
                    if (as !== es || bus_if.oWrnRam !== 4'hF) begin
                        bad++;
                        $display("FAIL sweep_cycle got csn=%h addr=%0d acc=%b sel=%0d add=%b sv=%b wrn=%h want csn=%h addr=%0d acc=%b sel=%0d add=%b sv=%b wrn=f",
                                 as.csn, as.addr, as.acc, as.sel, as.add, as.sv, bus_if.oWrnRam,
                                 es.csn, es.addr, es.acc, es.sel, es.add, es.sv);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_pulse();
        bus_if.iEnSample_300k = 1'b1;
        tick();
        bus_if.iEnSample_300k = 1'b0;
    endtask

    task automatic push_sweep();
        sw_t e;
        for (int c = 0; c < 13; c++) begin
            e.csn  = (c <= 9) ? 4'h0 : 4'hF;
            e.addr = (c <= 9) ? 4'(c) : 4'h0;
            e.acc  = (c >= 1 && c <= 10);
            e.sel  = (c >= 1 && c <= 10) ? 4'(c - 1) : 4'h0;
            e.add  = (c == 11);
            e.sv   = (c == 12);
            sb_s.push_back(e);
        end
    endtask

    task automatic wait_sweep_drained();
        for (int i = 0; i < 40 && sb_s.size() != 0; i++) tick();
    endtask

    task automatic do_load(input bit send_update, input bit toggle, input bit rnd,
                           input int n_words, output int accepted);
        int          k = 0;
        int          cyc = 0;
        logic [15:0] d;
        write_count = 0;
        done_count  = 0;
        for (int i = 0; i < 40; i++) hits[i] = 0;
        if (send_update) begin
            bus_if.iCoeffUpdate = 1'b1;
            tick();
            bus_if.iCoeffUpdate = 1'b0;
        end
        while (k < n_words && cyc < 400) begin
            bus_if.iCoeffValid = toggle ? (cyc % 2 == 0) : 1'b1;
            d = rnd ? 16'($urandom_range(0, 65535)) : 16'(16'h0100 + k);
            bus_if.iCoeffData = d;
            @(negedge clk);
            if (bus_if.iCoeffValid && bus_if.oCoeffReady) begin
                sb_w.push_back('{bank: 2'(k / 10), addr: 4'(k % 10), data: d, last: (k == 39)});
                k++;
            end
            tick();
            cyc++;
        end
        bus_if.iCoeffValid = 1'b0;
        accepted = k;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({bus_if.oCsnRam, bus_if.oWrnRam, bus_if.oAddrRam, bus_if.oWrDtRam, bus_if.oSel} !== {4'hF, 4'hF, 4'h0, 16'h0, 4'h0}) begin
            bad++;
            $display("FAIL reset_bus got csn=%h wrn=%h addr=%h data=%h sel=%h want f f 0 0000 0",
                     bus_if.oCsnRam, bus_if.oWrnRam, bus_if.oAddrRam, bus_if.oWrDtRam, bus_if.oSel);
        end
        total++;
        if ({bus_if.oCoeffReady, bus_if.oEnAcc, bus_if.oEnAdd, bus_if.oSumValid, bus_if.oLoadDone, bus_if.oBusy, bus_if.oOverrun} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got rdy/acc/add/sv/done/busy/ovr=%b want 0000000",
                     {bus_if.oCoeffReady, bus_if.oEnAcc, bus_if.oEnAdd, bus_if.oSumValid,
                      bus_if.oLoadDone, bus_if.oBusy, bus_if.oOverrun});
        end
        #20 rst_n = 1'b1;
        tick();
        strobe_pulse();
        repeat (20) tick();
        total++;
        if (bus_if.oBusy !== 1'b0 || bus_if.oOverrun !== 1'b0) begin
            bad++;
            $display("FAIL idle_strobe got busy=%b ovr=%b want 0 0", bus_if.oBusy, bus_if.oOverrun);
        end
    endtask

    task automatic test_load_burst();
        int acc;
        int badslots = 0;
        do_load(1'b1, 1'b0, 1'b0, 40, acc);
        @(negedge clk);
        tick();
        total++;
        if (acc !== 40 || write_count !== 40 || sb_w.size() !== 0) begin
            bad++;
            $display("FAIL burst_count got acc=%0d writes=%0d left=%0d want 40 40 0", acc, write_count, sb_w.size());
        end
        total++;
        if (done_count !== 1) begin
            bad++;
            $display("FAIL burst_done got pulses=%0d want 1", done_count);
        end
        total++;
        if (bus_if.oCoeffReady !== 1'b0 || bus_if.oBusy !== 1'b0) begin
            bad++;
            $display("FAIL burst_armed got ready=%b busy=%b want 0 0", bus_if.oCoeffReady, bus_if.oBusy);
        end
        for (int i = 0; i < 40; i++) if (hits[i] != 1) badslots++;
        total++;
        if (badslots !== 0) begin
            bad++;
            $display("FAIL burst_slots got badslots=%0d want 0", badslots);
        end
    endtask

    task automatic test_load_toggle();
        int acc;
        int badslots = 0;
        do_load(1'b1, 1'b1, 1'b1, 40, acc);
        @(negedge clk);
        tick();
        for (int i = 0; i < 40; i++) if (hits[i] != 1) badslots++;
        total++;
        if (acc !== 40 || write_count !== 40 || sb_w.size() !== 0 || badslots !== 0) begin
            bad++;
            $display("FAIL toggle_load got acc=%0d writes=%0d left=%0d badslots=%0d want 40 40 0 0",
                     acc, write_count, sb_w.size(), badslots);
        end
        total++;
        if (done_count !== 1 || bus_if.oCoeffReady !== 1'b0) begin
            bad++;
            $display("FAIL toggle_done got pulses=%0d ready=%b want 1 0", done_count, bus_if.oCoeffReady);
        end
    endtask

    task automatic test_sweep();
        push_sweep();
        strobe_pulse();
        total++;
        if (bus_if.oBusy !== 1'b1) begin
            bad++;
            $display("FAIL sweep_busy got %b want 1", bus_if.oBusy);
        end
        wait_sweep_drained();
        total++;
        if (sb_s.size() !== 0 || bus_if.oOverrun !== 1'b0 || bus_if.oBusy !== 1'b0) begin
            bad++;
            $display("FAIL sweep_end got left=%0d ovr=%b busy=%b want 0 0 0", sb_s.size(), bus_if.oOverrun, bus_if.oBusy);
        end
    endtask

    task automatic test_back_to_back();
        push_sweep();
        push_sweep();
        strobe_pulse();
        repeat (12) tick();
        strobe_pulse();
        wait_sweep_drained();
        total++;
        if (sb_s.size() !== 0 || bus_if.oOverrun !== 1'b0) begin
            bad++;
            $display("FAIL b2b got left=%0d ovr=%b want 0 0", sb_s.size(), bus_if.oOverrun);
        end
    endtask

    task automatic test_overrun();
        push_sweep();
        strobe_pulse();
        repeat (5) tick();
        strobe_pulse();
        total++;
        if (bus_if.oOverrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set got %b want 1", bus_if.oOverrun);
        end
        wait_sweep_drained();
        repeat (15) tick();
        total++;
        if (sb_s.size() !== 0 || bus_if.oOverrun !== 1'b1 || bus_if.oBusy !== 1'b0) begin
            bad++;
            $display("FAIL overrun_end got left=%0d ovr=%b busy=%b want 0 1 0", sb_s.size(), bus_if.oOverrun, bus_if.oBusy);
        end
    endtask

    task automatic test_update_mid_sweep();
        int acc;
        push_sweep();
        strobe_pulse();
        repeat (3) tick();
        bus_if.iCoeffUpdate = 1'b1;
        tick();
        bus_if.iCoeffUpdate = 1'b0;
        wait_sweep_drained();
        total++;
        if (sb_s.size() !== 0 || bus_if.oCoeffReady !== 1'b1 || bus_if.oBusy !== 1'b1 || bus_if.oOverrun !== 1'b0) begin
            bad++;
            $display("FAIL update_to_load got left=%0d ready=%b busy=%b ovr=%b want 0 1 1 0",
                     sb_s.size(), bus_if.oCoeffReady, bus_if.oBusy, bus_if.oOverrun);
        end
        do_load(1'b0, 1'b0, 1'b1, 40, acc);
        @(negedge clk);
        tick();
        total++;
        if (acc !== 40 || sb_w.size() !== 0 || done_count !== 1) begin
            bad++;
            $display("FAIL update_reload got acc=%0d left=%0d pulses=%0d want 40 0 1", acc, sb_w.size(), done_count);
        end
    endtask

    task automatic test_reset_mid_load();
        int acc;
        do_load(1'b1, 1'b0, 1'b1, 17, acc);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus_if.oCsnRam !== 4'hF || bus_if.oWrnRam !== 4'hF || bus_if.oCoeffReady !== 1'b0 || bus_if.oBusy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got csn=%h wrn=%h ready=%b busy=%b want f f 0 0",
                     bus_if.oCsnRam, bus_if.oWrnRam, bus_if.oCoeffReady, bus_if.oBusy);
        end
        sb_w.delete();
        #20 rst_n = 1'b1;
        tick();
        strobe_pulse();
        repeat (20) tick();
        total++;
        if (bus_if.oBusy !== 1'b0 || sb_s.size() !== 0) begin
            bad++;
            $display("FAIL no_sweep_unloaded got busy=%b left=%0d want 0 0", bus_if.oBusy, sb_s.size());
        end
        do_load(1'b1, 1'b0, 1'b0, 40, acc);
        @(negedge clk);
        tick();
        total++;
        if (acc !== 40 || sb_w.size() !== 0 || done_count !== 1) begin
            bad++;
            $display("FAIL reload_after_reset got acc=%0d left=%0d pulses=%0d want 40 0 1", acc, sb_w.size(), done_count);
        end
        push_sweep();
        strobe_pulse();
        wait_sweep_drained();
        total++;
        if (sb_s.size() !== 0) begin
            bad++;
            $display("FAIL sweep_after_reload got left=%0d want 0", sb_s.size());
        end
    endtask

    initial begin
        bus_if.iEnSample_300k = 1'b0;
        bus_if.iCoeffUpdate   = 1'b0;
        bus_if.iCoeffValid    = 1'b0;
        bus_if.iCoeffData     = '0;
        write_count           = 0;
        done_count            = 0;
        fork
            monitor();
        join_none
        test_reset();
        test_load_burst();
        test_load_toggle();
        test_sweep();
        test_back_to_back();
        test_overrun();
        test_update_mid_sweep();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
